// File: rtl/quad_decoder_if.sv
// Signal bundle between the encoder-pin side and the quadrature decoder.
// master: drives the raw phases and controls, observes the count outputs.
// slave : the decoder itself.
interface quad_decoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             a_in;
    logic             b_in;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             step;
    logic             wrap;
    logic             err;

    modport master (
        output a_in, b_in, en, clr,
        input  count, dir, step, wrap, err
    );

    modport slave (
        input  a_in, b_in, en, clr,
        output count, dir, step, wrap, err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature receiver: synchronises and glitch-filters the A/B phase pair,
// decodes Gray-code transitions into up/down steps and keeps a wrapping
// position count. Double-bit transitions raise a sticky error flag.
module quad_decoder #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FILT_LEN = 2
) (
    input logic           clk,
    input logic           rst,
    quad_decoder_if.slave bus
);

    // Stability counter only has to reach FILT_LEN-1.
    localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
    // Edges after reset before s2 holds a genuine pin sample.
    localparam logic [1:0] PRIME_DONE = 2'd2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Synchroniser
    logic [1:0]        s1_q;
    logic [1:0]        s2_q;

    // Filter
    logic [1:0]        cand_q, cand_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [1:0]        filt_q, filt_d;
    logic              accept;

    // Init tracking
    state_t            state_q, state_d;
    logic [1:0]        prime_q, prime_d;

    // Transition classification
    logic              trans_up;
    logic              trans_dn;
    logic              trans_bad;
    logic              counted;

    // Outputs
    logic [CNT_W-1:0]  count_q, count_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;

    // Two-flop synchroniser on the raw asynchronous phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {bus.a_in, bus.b_in};
            s2_q <= s1_q;
        end
    end

    // Glitch filter: a new level must be seen unchanged long enough before
    // it is promoted to the filtered state.
    always_comb begin
        cand_d = cand_q;
        fcnt_d = fcnt_q;
        filt_d = filt_q;
        accept = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            fcnt_d = '0;
        end else if (cand_q != filt_q) begin
            if (fcnt_q == FCNT_LAST) begin
                filt_d = cand_q;
                accept = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= '0;
            fcnt_q <= '0;
            filt_q <= '0;
        end else begin
            cand_q <= cand_d;
            fcnt_q <= fcnt_d;
            filt_q <= filt_d;
        end
    end

    // Classify the transition old filtered state -> accepted candidate.
    always_comb begin
        trans_up  = 1'b0;
        trans_dn  = 1'b0;
        trans_bad = 1'b0;
        case ({filt_q, cand_q})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: trans_up  = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: trans_dn  = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: trans_bad = 1'b1;
            default: ;
        endcase
    end

    // Init state register and synchroniser priming counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            prime_q <= '0;
        end else begin
            state_q <= state_d;
            prime_q <= prime_d;
        end
    end

    // Init leaves on the first accepted level (adopted silently), or once the
    // primed synchroniser agrees with a settled filter that already matches q.
    always_comb begin
        state_d = state_q;
        prime_d = prime_q;
        if (prime_q != PRIME_DONE) begin
            prime_d = prime_q + 2'd1;
        end
        case (state_q)
            ST_INIT: begin
                if (accept) begin
                    state_d = ST_RUN;
                end else if (prime_q == PRIME_DONE && s2_q == cand_q && cand_q == filt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign counted = accept && (state_q == ST_RUN);

    // Count, direction, pulses and sticky error. clr clears count and err,
    // but a coincident step still pulses and a coincident illegal edge
    // still sets err.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (bus.clr) begin
            count_d = '0;
            err_d   = 1'b0;
        end
        if (counted) begin
            if (trans_bad) begin
                err_d = 1'b1;
            end else if (bus.en && (trans_up || trans_dn)) begin
                step_d = 1'b1;
                dir_d  = trans_up;
                if (!bus.clr) begin
                    if (trans_up) begin
                        count_d = count_q + 1'b1;
                        wrap_d  = (count_q == '1);
                    end else begin
                        count_d = count_q - 1'b1;
                        wrap_d  = (count_q == '0);
                    end
                end
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.step  = step_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: table of held input levels with expected end state,
// hand-written corner sequences, and random level sequences, all tracked
// cycle by cycle against a level-history reference model.
module tb_quad_decoder;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned FILT_LEN = 2;
    localparam int          HLEN     = 16;
    localparam int          MODULUS  = 1 << CNT_W;

    logic clk = 1'b0;
    logic rst;

    quad_decoder_if #(.CNT_W(CNT_W)) bus ();

    quad_decoder #(
        .CNT_W   (CNT_W),
        .FILT_LEN(FILT_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // Reference model: history of the level sampled at each edge, and the
    // decoder's architectural state.
    logic [1:0] hist [HLEN];
    int         edge_n;
    logic [1:0] m_q;
    int         m_count;
    logic       m_dir, m_step, m_wrap, m_err;
    int         m_init;

    typedef struct {
        logic [1:0] ab;
        int         hold;
        logic       en;
        logic       clr;
        int         cnt;
        logic       dir;
        logic       err;
        int         steps;
        int         wraps;
    } vec_t;

    vec_t tbl[$];

    // Position of a phase pair along the up sequence 00,01,11,10.
    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // A level first sampled at edge s and held FILT_LEN+1 samples becomes the
    // filtered state at edge s+FILT_LEN+2.
    task automatic model_edge(input logic [1:0] ab, input logic en_v, input logic clr_v, input logic rst_v);
        logic [1:0] v;
        bit         ev;
        int         d;
        int         nc;
        edge_n++;
        hist[edge_n % HLEN] = rst_v ? 2'b00 : ab;
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (rst_v) begin
            m_q     = 2'b00;
            m_count = 0;
            m_dir   = 1'b1;
            m_err   = 1'b0;
            m_init  = FILT_LEN + 3;
            return;
        end
        v  = hist[(edge_n - FILT_LEN - 2) % HLEN];
        ev = (v != m_q) && (hist[(edge_n - FILT_LEN - 3) % HLEN] != v);
        for (int k = 0; k <= FILT_LEN; k++)
            if (hist[(edge_n - FILT_LEN - 2 + k) % HLEN] != v) ev = 0;
        if (clr_v) begin
            m_count = 0;
            m_err   = 1'b0;
        end
        if (ev) begin
            d = (gpos(v) - gpos(m_q) + 4) % 4;
            if (m_init > 0) begin
                m_init = 0;
            end else if (d == 2) begin
                m_err = 1'b1;
            end else if (en_v) begin
                m_step = 1'b1;
                m_dir  = (d == 1);
                if (!clr_v) begin
                    nc      = m_count + ((d == 1) ? 1 : -1);
                    m_wrap  = (nc < 0) || (nc >= MODULUS);
                    m_count = (nc + MODULUS) % MODULUS;
                end
            end
            m_q = v;
        end
        if (m_init > 0) m_init--;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic tick(input logic [1:0] ab, input logic en_v, input logic clr_v, input logic rst_v);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
        bus.en   = en_v;
        bus.clr  = clr_v;
        rst      = rst_v;
        @(posedge clk);
        model_edge(ab, en_v, clr_v, rst_v);
        #1;
        nvec++;
        if ({bus.count, bus.dir, bus.step, bus.wrap, bus.err} !==
            {CNT_W'(m_count), m_dir, m_step, m_wrap, m_err}) begin
            nfail++;
            $display("FAIL cycle t=%0t: count=%0h dir=%b step=%b wrap=%b err=%b, expected count=%0h dir=%b step=%b wrap=%b err=%b",
                     $time, bus.count, bus.dir, bus.step, bus.wrap, bus.err,
                     CNT_W'(m_count), m_dir, m_step, m_wrap, m_err);
        end
    endtask

    task automatic seg(input logic [1:0] ab, input int hold, input logic en_v, input logic clr_v,
                       output int steps, output int wraps);
        steps = 0;
        wraps = 0;
        for (int i = 0; i < hold; i++) begin
            tick(ab, en_v, clr_v, 1'b0);
            steps += int'(bus.step);
            wraps += int'(bus.wrap);
        end
    endtask

    task automatic add(input logic [1:0] ab, input int hold, input logic en_v, input logic clr_v,
                       input int cnt, input logic dir, input logic err, input int steps, input int wraps);
        vec_t r;
        r.ab = ab; r.hold = hold; r.en = en_v; r.clr = clr_v;
        r.cnt = cnt; r.dir = dir; r.err = err; r.steps = steps; r.wraps = wraps;
        tbl.push_back(r);
    endtask

    initial begin
        int st, wr;
        logic [1:0] ab;
        int hold;
        logic en_v;

        for (int i = 0; i < HLEN; i++) hist[i] = 2'b00;
        edge_n = HLEN;
        m_q = 2'b00; m_count = 0; m_dir = 1'b1; m_step = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
        m_init = FILT_LEN + 3;
        rst = 1'b1;
        bus.a_in = 1'b0; bus.b_in = 1'b0; bus.en = 1'b1; bus.clr = 1'b0;

        //           ab     hold en    clr   cnt   dir   err   steps wraps
        add(2'b01, 10, 1'b1, 1'b0, 1,    1'b1, 1'b0, 1, 0);
        add(2'b11, 10, 1'b1, 1'b0, 2,    1'b1, 1'b0, 1, 0);
        add(2'b10, 10, 1'b1, 1'b0, 3,    1'b1, 1'b0, 1, 0);
        add(2'b00, 10, 1'b1, 1'b0, 4,    1'b1, 1'b0, 1, 0);
        add(2'b10, 10, 1'b1, 1'b0, 3,    1'b0, 1'b0, 1, 0);
        add(2'b00, 10, 1'b1, 1'b0, 4,    1'b1, 1'b0, 1, 0);
        add(2'b01,  2, 1'b1, 1'b0, 4,    1'b1, 1'b0, 0, 0);
        add(2'b00, 10, 1'b1, 1'b0, 4,    1'b1, 1'b0, 0, 0);
        add(2'b01,  3, 1'b1, 1'b0, 4,    1'b1, 1'b0, 0, 0);
        add(2'b00, 10, 1'b1, 1'b0, 4,    1'b0, 1'b0, 2, 0);
        add(2'b11, 10, 1'b1, 1'b0, 4,    1'b0, 1'b1, 0, 0);
        add(2'b10, 10, 1'b1, 1'b0, 5,    1'b1, 1'b1, 1, 0);
        add(2'b10,  2, 1'b1, 1'b1, 0,    1'b1, 1'b0, 0, 0);
        add(2'b00, 10, 1'b0, 1'b0, 0,    1'b1, 1'b0, 0, 0);
        add(2'b01, 10, 1'b0, 1'b0, 0,    1'b1, 1'b0, 0, 0);
        add(2'b11, 10, 1'b0, 1'b0, 0,    1'b1, 1'b0, 0, 0);
        add(2'b10, 10, 1'b0, 1'b0, 0,    1'b1, 1'b0, 0, 0);
        add(2'b00, 10, 1'b1, 1'b0, 1,    1'b1, 1'b0, 1, 0);
        add(2'b00,  2, 1'b1, 1'b1, 0,    1'b1, 1'b0, 0, 0);
        add(2'b10, 10, 1'b1, 1'b0, 255,  1'b0, 1'b0, 1, 1);
        add(2'b00, 10, 1'b1, 1'b0, 0,    1'b1, 1'b0, 1, 1);

        // Reset with both phases low, then check reset values.
        for (int i = 0; i < 3; i++) tick(2'b00, 1'b1, 1'b0, 1'b1);
        chk("reset count", int'(bus.count), 0);
        chk("reset dir",   int'(bus.dir),   1);
        chk("reset step",  int'(bus.step),  0);
        chk("reset wrap",  int'(bus.wrap),  0);
        chk("reset err",   int'(bus.err),   0);
        seg(2'b00, 8, 1'b1, 1'b0, st, wr);
        chk("init no step", st, 0);

        foreach (tbl[i]) begin
            seg(tbl[i].ab, tbl[i].hold, tbl[i].en, tbl[i].clr, st, wr);
            chk($sformatf("row%0d count", i), int'(bus.count), tbl[i].cnt);
            chk($sformatf("row%0d dir", i),   int'(bus.dir),   int'(tbl[i].dir));
            chk($sformatf("row%0d err", i),   int'(bus.err),   int'(tbl[i].err));
            chk($sformatf("row%0d steps", i), st, tbl[i].steps);
            chk($sformatf("row%0d wraps", i), wr, tbl[i].wraps);
        end

        // clr on the same edge as an up step: count cleared, step still pulses.
        for (int i = 0; i < 4; i++) tick(2'b01, 1'b1, 1'b0, 1'b0);
        tick(2'b01, 1'b1, 1'b1, 1'b0);
        chk("clr+step count", int'(bus.count), 0);
        chk("clr+step step",  int'(bus.step),  1);
        chk("clr+step dir",   int'(bus.dir),   1);
        chk("clr+step wrap",  int'(bus.wrap),  0);
        seg(2'b01, 5, 1'b1, 1'b0, st, wr);

        // clr on the same edge as an illegal transition: err set wins.
        for (int i = 0; i < 4; i++) tick(2'b10, 1'b1, 1'b0, 1'b0);
        tick(2'b10, 1'b1, 1'b1, 1'b0);
        chk("clr+bad err",   int'(bus.err),   1);
        chk("clr+bad count", int'(bus.count), 0);
        chk("clr+bad step",  int'(bus.step),  0);
        seg(2'b10, 5, 1'b1, 1'b0, st, wr);

        // Reset with both phases high: level adopted silently.
        for (int i = 0; i < 2; i++) tick(2'b11, 1'b1, 1'b0, 1'b1);
        seg(2'b11, 10, 1'b1, 1'b0, st, wr);
        chk("rst11 steps", st, 0);
        chk("rst11 err",   int'(bus.err),   0);
        chk("rst11 count", int'(bus.count), 0);
        seg(2'b10, 10, 1'b1, 1'b0, st, wr);
        chk("rst11 up count", int'(bus.count), 1);
        chk("rst11 up dir",   int'(bus.dir),   1);

        // Reset two cycles after a raw change: in-flight level discarded.
        seg(2'b00, 2, 1'b1, 1'b0, st, wr);
        tick(2'b00, 1'b1, 1'b0, 1'b1);
        seg(2'b00, 10, 1'b1, 1'b0, st, wr);
        chk("midrst count", int'(bus.count), 0);
        chk("midrst steps", st, 0);
        chk("midrst err",   int'(bus.err),   0);

        // Random level sequences with occasional clr and en=0.
        for (int n = 0; n < 400; n++) begin
            ab   = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 6);
            en_v = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < hold; i++)
                tick(ab, en_v, ($urandom_range(0, 39) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
